bvadd_inv_solver: RTL and testbench

- Parametrised, sequential successor to the fixed 4-bit combinational invertibility solver for x + s >s t.
- Given operands s and t and a predicate op, it produces x such that (x + s) op t holds. It also reports whether any such x exists.
- An on-chip bit-serial checker re-evaluates the predicate on the produced x, so every result is self-verified.
- Sits between the query front-end and the result collector of the SMT invertibility pipeline; single request in flight.

---
 rtl/bvadd_inv_solver.sv | 170 +++++++++++++++++
 tb/tb_bvadd_inv_solver.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bvadd_inv_solver.sv
// Sequential invertibility solver for (x + s) op t over W-bit vectors.
// Computes a witness x and sat in one cycle, then re-checks the predicate bit-serially.
module bvadd_inv_solver #(
    parameter int W     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_s,
    input  logic [W-1:0]     in_t,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_x,
    output logic             out_sat,
    output logic             out_chk,
    output logic             err_sticky,
    output logic [CNT_W-1:0] solved_cnt
);
    localparam int IW = $clog2(W);
    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONES = {W{1'b1}};

    typedef enum logic [1:0] {IDLE, CALC, CHECK, DONE} state_t;
    typedef enum logic [1:0] {REL_LT, REL_EQ, REL_GT} rel_t;

    state_t           state_reg, state_next;
    logic [W-1:0]     s_reg, t_reg, x_reg;
    logic [2:0]       op_reg;
    logic             sat_reg, chk_reg, carry_reg, err_reg;
    logic [IW-1:0]    idx_reg;
    rel_t             rel_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [W-1:0]     x_calc;
    logic             sat_calc;
    logic             sum_bit, t_bit, carry_next, last_bit, signed_op;
    rel_t             rel_step;
    logic             chk_eval;

    assign in_ready   = (state_reg == IDLE) && !rst;
    assign out_valid  = (state_reg == DONE);
    assign out_x      = x_reg;
    assign out_sat    = sat_reg;
    assign out_chk    = chk_reg;
    assign err_sticky = err_reg;
    assign solved_cnt = cnt_reg;

    always_comb begin
        x_calc   = '0;
        sat_calc = 1'b1;
        case (op_reg)
            3'd0: x_calc = t_reg - s_reg;
            3'd1: x_calc = t_reg + W'(1) - s_reg;
            3'd2: begin
                sat_calc = (t_reg != ONES);
                x_calc   = t_reg + W'(1) - s_reg;
            end
            3'd3: x_calc = t_reg - s_reg;
            3'd4: begin
                sat_calc = (t_reg != '0);
                x_calc   = W'(0) - s_reg;
            end
            3'd5: x_calc = W'(0) - s_reg;
            3'd6: begin
                sat_calc = (t_reg != SMAX);
                x_calc   = t_reg + W'(1) - s_reg;
            end
            default: begin
                sat_calc = (t_reg != SMIN);
                x_calc   = SMIN - s_reg;
            end
        endcase
        if (!sat_calc) begin
            x_calc = '0;
        end
    end

    // Serial compare: a later (more significant) differing bit overrides the verdict;
    // for signed ops the sign bit has inverted weight.
    always_comb begin
        last_bit   = (idx_reg == IW'(W-1));
        signed_op  = (op_reg == 3'd6) || (op_reg == 3'd7);
        sum_bit    = x_reg[idx_reg] ^ s_reg[idx_reg] ^ carry_reg;
        t_bit      = t_reg[idx_reg];
        carry_next = (x_reg[idx_reg] & s_reg[idx_reg]) | (carry_reg & (x_reg[idx_reg] ^ s_reg[idx_reg]));
        rel_step   = rel_reg;
        if (sum_bit != t_bit) begin
            rel_step = (sum_bit ^ (signed_op & last_bit)) ? REL_GT : REL_LT;
        end
        case (op_reg)
            3'd0:         chk_eval = (rel_step == REL_EQ);
            3'd1:         chk_eval = (rel_step != REL_EQ);
            3'd2, 3'd6:   chk_eval = (rel_step == REL_GT);
            3'd3:         chk_eval = (rel_step != REL_LT);
            3'd4, 3'd7:   chk_eval = (rel_step == REL_LT);
            default:      chk_eval = (rel_step != REL_GT);
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = CALC;
            CALC:    state_next = CHECK;
            CHECK:   if (last_bit) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg     <= '0;
            t_reg     <= '0;
            op_reg    <= '0;
            x_reg     <= '0;
            sat_reg   <= 1'b0;
            chk_reg   <= 1'b0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            rel_reg   <= REL_EQ;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        s_reg  <= in_s;
                        t_reg  <= in_t;
                        op_reg <= in_op;
                    end
                end
                CALC: begin
                    x_reg     <= x_calc;
                    sat_reg   <= sat_calc;
                    idx_reg   <= '0;
                    carry_reg <= 1'b0;
                    rel_reg   <= REL_EQ;
                end
                CHECK: begin
                    carry_reg <= carry_next;
                    rel_reg   <= rel_step;
                    idx_reg   <= idx_reg + IW'(1);
                    if (last_bit) begin
                        chk_reg <= chk_eval;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        cnt_reg <= cnt_reg + CNT_W'(sat_reg);
                        err_reg <= err_reg | (chk_reg != sat_reg);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bvadd_inv_solver.sv
// Randomized/exhaustive bench for bvadd_inv_solver with a predicate-level reference model.
module tb_bvadd_inv_solver;
    localparam int W     = 4;
    localparam int CNT_W = 4;
    localparam int M     = 1 << W;

    logic             clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]     in_s, in_t, out_x;
    logic [2:0]       in_op;
    logic             out_sat, out_chk, err_sticky;
    logic [CNT_W-1:0] solved_cnt;

    bvadd_inv_solver #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_s(in_s), .in_t(in_t), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_sat(out_sat), .out_chk(out_chk),
        .err_sticky(err_sticky), .solved_cnt(solved_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit rand_ready = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int sg(input int v);
        return (v >= M / 2) ? v - M : v;
    endfunction

    function automatic bit pred(input int a, input int b, input int op);
        case (op)
            0: return a == b;
            1: return a != b;
            2: return a > b;
            3: return a >= b;
            4: return a < b;
            5: return a <= b;
            6: return sg(a) > sg(b);
            default: return sg(a) < sg(b);
        endcase
    endfunction

    // Satisfiability by brute-force search; the witness from the closed-form rules.
    task automatic model(input int s, input int t, input int op,
                         output int x, output int sat, output int c);
        sat = 0;
        for (int xx = 0; xx < M; xx++) begin
            if (pred((xx + s) % M, t, op)) sat = 1;
        end
        case (op)
            0, 3:    x = (t - s + M) % M;
            1, 2, 6: x = (t + 1 - s + 2 * M) % M;
            4, 5:    x = (M - s) % M;
            default: x = (M / 2 - s + M) % M;
        endcase
        if (sat == 0) x = 0;
        c = pred((x + s) % M, t, op) ? 1 : 0;
    endtask

    int m_st = 0, m_timer = 0, m_x = 0, m_sat = 0, m_chk = 0, m_cnt = 0, m_err = 0;
    bit m_live = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready_during_rst", in_ready, 0);
            m_st = 0; m_cnt = 0; m_err = 0; m_live = 1'b1;
        end else if (m_live) begin
            chk("in_ready", in_ready, (m_st == 0) ? 1 : 0);
            chk("out_valid", out_valid, (m_st == 2) ? 1 : 0);
            chk("err_sticky", err_sticky, m_err);
            chk("solved_cnt", solved_cnt, m_cnt);
            if (m_st == 2) begin
                chk("out_x", out_x, m_x);
                chk("out_sat", out_sat, m_sat);
                chk("out_chk", out_chk, m_chk);
            end
            case (m_st)
                0: if (in_valid) begin
                    model(in_s, in_t, in_op, m_x, m_sat, m_chk);
                    m_st = 1; m_timer = 0;
                end
                1: begin
                    m_timer++;
                    if (m_timer == W + 1) m_st = 2;
                end
                default: if (out_ready) begin
                    m_cnt = (m_cnt + m_sat) % (1 << CNT_W);
                    m_err = m_err | ((m_chk != m_sat) ? 1 : 0);
                    m_st = 0;
                end
            endcase
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom % 2) == 1;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic submit(input int s, input int t, input int op);
        bit ok;
        ok = 1'b0;
        in_s = W'(s); in_t = W'(t); in_op = 3'(op); in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_timeout", ok, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic junk(input int n);
        repeat (n) begin
            in_valid = ($urandom % 2) == 1;
            in_s = W'($urandom); in_t = W'($urandom); in_op = 3'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic do_req(input int s, input int t, input int op,
                          input int ex, input int esat, input int echk);
        int lat;
        bit found;
        lat = 0; found = 1'b0;
        submit(s, t, op);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("result_timeout", found, 1);
        chk("latency", lat, W + 2);
        chk("lit_x", out_x, ex);
        chk("lit_sat", out_sat, esat);
        chk("lit_chk", out_chk, echk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_s = '0; in_t = '0; in_op = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_out_chk", out_chk, 0);
        chk("rst_err", err_sticky, 0);
        chk("rst_cnt", solved_cnt, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        do_req(3, 5, 6, 3, 1, 1);
        @(negedge clk);
        chk("cnt_after_first", solved_cnt, 1);
        do_req(2, 7, 6, 0, 0, 0);
        @(negedge clk);
        chk("cnt_unsat_unchanged", solved_cnt, 1);
        chk("err_after_unsat", err_sticky, 0);
        do_req(5, 0, 4, 0, 0, 0);
        do_req(5, 0, 5, 11, 1, 1);

        rand_ready = 1'b1;
        for (int op = 0; op < 8; op++) begin
            for (int s = 0; s < M; s++) begin
                for (int t = 0; t < M; t++) begin
                    submit(s, t, op);
                    junk(W + 1);
                end
            end
        end
        @(posedge clk);
        #2;
        rand_ready = 1'b0;
        out_ready = 1'b1;
        repeat (W + 6) @(posedge clk);
        #1;
        chk("sweep_err_sticky", err_sticky, 0);

        submit(1, 2, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_x", out_x, 0);
        chk("abort_out_sat", out_sat, 0);
        chk("abort_out_chk", out_chk, 0);
        chk("abort_cnt", solved_cnt, 0);
        chk("abort_in_ready", in_ready, 1);
        repeat (10) @(posedge clk);
        #1;
        do_req(4, 9, 3, 5, 1, 1);

        for (int i = 0; i < 16; i++) begin
            submit(i, (i * 7) % M, 0);
            junk(W + 1);
        end
        repeat (W + 6) @(posedge clk);
        @(negedge clk);
        chk("cnt_wrap", solved_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
